// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter:
// state encoding, requester identities and default widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// The clear input has priority over inc.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared block memory between the instruction and data caches.
// Ties alternate using the last-served requester; a grant is held until mem_ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  ic_grants,
  output logic [CNT_W-1:0]  dc_grants
);

  state_t            r_state;
  state_t            w_state_next;
  req_id_t           r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              w_dc_req;
  logic              w_active;

  assign w_dc_req = dc_read | dc_write;
  assign w_active = (r_state == GNT_I) || (r_state == GNT_D);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (ic_read && w_dc_req) begin
          w_state_next = (r_last_gnt == REQ_D) ? GNT_I : GNT_D;
        end else if (ic_read) begin
          w_state_next = GNT_I;
        end else if (w_dc_req) begin
          w_state_next = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state    <= IDLE;
      r_last_gnt <= REQ_D;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      // The request is captured once; the caches may change their inputs afterwards.
      if ((r_state == IDLE) && (w_state_next == GNT_I)) begin
        r_addr  <= ic_addr;
        r_write <= 1'b0;
        r_wdata <= '0;
      end else if ((r_state == IDLE) && (w_state_next == GNT_D)) begin
        r_addr  <= dc_addr;
        r_write <= dc_write;
        r_wdata <= dc_write ? dc_wdata : '0;
      end
      if (ic_ready) begin
        r_last_gnt <= REQ_I;
      end else if (dc_ready) begin
        r_last_gnt <= REQ_D;
      end
    end
  end

  assign mem_read  = w_active && !r_write;
  assign mem_write = w_active && r_write;
  assign mem_addr  = w_active ? r_addr : '0;
  assign mem_wdata = w_active ? r_wdata : '0;

  // Reset abandons the transfer, so a coincident mem_ready is not acknowledged.
  assign ic_ready = (r_state == GNT_I) && mem_ready && !proc_reset;
  assign dc_ready = (r_state == GNT_D) && mem_ready && !proc_reset;
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

  sat_counter #(.CNT_W(CNT_W)) u_ic_cnt (
    .clk   (clk),
    .clear (proc_reset),
    .inc   (ic_ready),
    .count (ic_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dc_cnt (
    .clk   (clk),
    .clear (proc_reset),
    .inc   (dc_ready),
    .count (dc_grants)
  );

endmodule
